// File: rtl/aes_shift_rows_pipe.sv
// Pipelined ShiftRows / InvShiftRows stage for 4 x NumCols Rijndael states.
// The direction travels with each beat; valid/ready handshake with a synchronous flush.
module aes_shift_rows_pipe #(
  parameter  int unsigned NumCols = 4,
  parameter  int unsigned Depth   = 1,
  localparam int unsigned Bw      = 32 * NumCols
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic          op_i,
  input  logic [Bw-1:0] data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic          op_o,
  output logic [Bw-1:0] data_o,
  output logic          busy_o
);

  if (!(NumCols == 4 || NumCols == 6 || NumCols == 8)) begin : g_bad_cols
    $error("aes_shift_rows_pipe: NumCols must be 4, 6 or 8");
  end
  if (Depth < 1 || Depth > 4) begin : g_bad_depth
    $error("aes_shift_rows_pipe: Depth must be in 1..4");
  end

  // Rijndael row offsets: 256-bit blocks shift rows 2 and 3 one column further.
  function automatic int unsigned row_offset(input int unsigned r);
    if (NumCols == 8 && r >= 2) return r + 1;
    return r;
  endfunction

  logic [Bw-1:0] shifted;

  always_comb begin
    shifted = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < NumCols; c++) begin
        int unsigned src;
        src = op_i ? (c + NumCols - row_offset(r)) % NumCols
                   : (c + row_offset(r)) % NumCols;
        shifted[8*(r*NumCols + c) +: 8] = data_i[8*(r*NumCols + src) +: 8];
      end
    end
  end

  logic [Depth-1:0] valid_q, valid_d;
  logic [Depth-1:0] op_q, op_d;
  logic [Bw-1:0]    data_q [Depth];
  logic [Bw-1:0]    data_d [Depth];
  logic [Depth-1:0] ready;

  // Index k feeds stage k; index 0 is the input port.
  logic [Depth:0]   src_v;
  logic [Depth:0]   src_op;
  logic [Bw-1:0]    src_data [Depth+1];

  always_comb begin
    src_v[0]    = in_valid_i;
    src_op[0]   = op_i;
    src_data[0] = shifted;
    for (int unsigned k = 0; k < Depth; k++) begin
      src_v[k+1]    = valid_q[k];
      src_op[k+1]   = op_q[k];
      src_data[k+1] = data_q[k];
    end
  end

  // Stage k can advance unless it and every stage after it are full and the
  // output is stalled; expressed without a ready-to-ready chain.
  always_comb begin
    ready = '0;
    for (int unsigned k = 0; k < Depth; k++) begin
      logic full;
      full = 1'b1;
      for (int unsigned j = k; j < Depth; j++) begin
        full = full & valid_q[j];
      end
      ready[k] = out_ready_i | ~full;
    end
  end

  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    data_d  = data_q;
    for (int unsigned k = 0; k < Depth; k++) begin
      if (ready[k]) begin
        valid_d[k] = src_v[k];
        if (src_v[k]) begin
          op_d[k]   = src_op[k];
          data_d[k] = src_data[k];
        end
      end
    end
    if (clear_i) begin
      valid_d = '0;
      op_d    = '0;
      for (int unsigned k = 0; k < Depth; k++) begin
        data_d[k] = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      op_q    <= '0;
      for (int unsigned k = 0; k < Depth; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      data_q  <= data_d;
    end
  end

  assign in_ready_o  = ready[0];
  assign out_valid_o = valid_q[Depth-1];
  assign op_o        = op_q[Depth-1];
  assign data_o      = data_q[Depth-1];
  assign busy_o      = |valid_q;

endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// Scoreboard bench for aes_shift_rows_pipe: three instances (4/1, 8/2, 6/3 columns/depth).
module tb_aes_shift_rows_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic a_clear, a_in_valid, a_op_i, a_out_ready, a_in_ready, a_out_valid, a_op_o, a_busy;
  logic [127:0] a_data_i, a_data_o;
  logic b_clear, b_in_valid, b_op_i, b_out_ready, b_in_ready, b_out_valid, b_op_o, b_busy;
  logic [255:0] b_data_i, b_data_o;
  logic c_clear, c_in_valid, c_op_i, c_out_ready, c_in_ready, c_out_valid, c_op_o, c_busy;
  logic [191:0] c_data_i, c_data_o;
  logic c_rand, c_rnd_ready, c_ready_val, c_track;
  assign c_out_ready = c_rand ? c_rnd_ready : c_ready_val;

  aes_shift_rows_pipe #(.NumCols(4), .Depth(1)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(a_clear), .in_valid_i(a_in_valid),
    .in_ready_o(a_in_ready), .op_i(a_op_i), .data_i(a_data_i), .out_valid_o(a_out_valid),
    .out_ready_i(a_out_ready), .op_o(a_op_o), .data_o(a_data_o), .busy_o(a_busy));
  aes_shift_rows_pipe #(.NumCols(8), .Depth(2)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(b_clear), .in_valid_i(b_in_valid),
    .in_ready_o(b_in_ready), .op_i(b_op_i), .data_i(b_data_i), .out_valid_o(b_out_valid),
    .out_ready_i(b_out_ready), .op_o(b_op_o), .data_o(b_data_o), .busy_o(b_busy));
  aes_shift_rows_pipe #(.NumCols(6), .Depth(3)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(c_clear), .in_valid_i(c_in_valid),
    .in_ready_o(c_in_ready), .op_i(c_op_i), .data_i(c_data_i), .out_valid_o(c_out_valid),
    .out_ready_i(c_out_ready), .op_o(c_op_o), .data_o(c_data_o), .busy_o(c_busy));

  typedef struct { logic [255:0] d; logic op; } exp_t;
  exp_t qa[$], qb[$], qc[$];
  exp_t ea, eb, ec;
  int errors = 0;
  int checks = 0;
  int inflight = 0;
  logic c_stall_prev = 1'b0;
  logic c_hold_op;
  logic [191:0] c_hold_d;

  localparam logic [127:0] A_IN  = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [127:0] A_FWD = 128'h0E0D0C0F_09080B0A_04070605_03020100;
  localparam logic [127:0] A_INV = 128'h0C0F0E0D_09080B0A_06050407_03020100;
  localparam logic [255:0] B_IN  = 256'h1F1E1D1C1B1A1918_1716151413121110_0F0E0D0C0B0A0908_0706050403020100;
  localparam logic [255:0] B_FWD = 256'h1B1A19181F1E1D1C_1211101716151413_080F0E0D0C0B0A09_0706050403020100;
  localparam logic [255:0] B_INV = 256'h1B1A19181F1E1D1C_1413121110171615_0E0D0C0B0A09080F_0706050403020100;
  localparam logic [191:0] C_IN  = 192'h171615141312_11100F0E0D0C_0B0A09080706_050403020100;
  localparam logic [191:0] C_FWD = 192'h141312171615_0D0C11100F0E_060B0A090807_050403020100;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference: rotate each row one column at a time, offset times.
  function automatic logic [255:0] model(input logic [255:0] d, input int nc, input logic op);
    logic [7:0] row [8];
    logic [7:0] t;
    logic [255:0] r;
    int sh;
    r = d;
    for (int rr = 0; rr < 4; rr++) begin
      sh = (nc == 8 && rr >= 2) ? rr + 1 : rr;
      for (int c = 0; c < nc; c++) row[c] = d[8*(rr*nc+c) +: 8];
      for (int s = 0; s < sh; s++) begin
        if (!op) begin
          t = row[0];
          for (int c = 0; c < nc - 1; c++) row[c] = row[c+1];
          row[nc-1] = t;
        end else begin
          t = row[nc-1];
          for (int c = nc - 1; c > 0; c--) row[c] = row[c-1];
          row[0] = t;
        end
      end
      for (int c = 0; c < nc; c++) r[8*(rr*nc+c) +: 8] = row[c];
    end
    return r;
  endfunction

  function automatic logic outv(input int w);
    case (w)
      0:       return a_out_valid;
      1:       return b_out_valid;
      default: return c_out_valid;
    endcase
  endfunction

  task automatic send(input int w, input logic [255:0] d, input logic op,
                      input logic [255:0] e, input bit push);
    bit got;
    got = 1'b0;
    case (w)
      0:       begin a_in_valid = 1'b1; a_data_i = d[127:0]; a_op_i = op; end
      1:       begin b_in_valid = 1'b1; b_data_i = d;        b_op_i = op; end
      default: begin c_in_valid = 1'b1; c_data_i = d[191:0]; c_op_i = op; end
    endcase
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      case (w)
        0:       got = a_in_ready;
        1:       got = b_in_ready;
        default: got = c_in_ready;
      endcase
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL send%0d_timeout: in_ready stayed 0, required 1", w);
    end else if (push) begin
      case (w)
        0:       qa.push_back('{d: e, op: op});
        1:       qb.push_back('{d: e, op: op});
        default: qc.push_back('{d: e, op: op});
      endcase
    end
    @(posedge clk); #1;
    case (w)
      0:       a_in_valid = 1'b0;
      1:       b_in_valid = 1'b0;
      default: c_in_valid = 1'b0;
    endcase
  endtask

  // Called 1 time unit after the accepting edge, with an empty pipe ahead.
  task automatic lat_check(input int w, input int depth);
    for (int i = 1; i < depth; i++) begin
      chk($sformatf("lat%0d_early_%0d", w, i), outv(w), 1'b0);
      @(posedge clk); #1;
    end
    chk($sformatf("lat%0d_on", w), outv(w), 1'b1);
  endtask

  task automatic drain();
    for (int n = 0; n < 1000 && (qa.size() + qb.size() + qc.size()) != 0; n++) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_extra: got beat %h, required none", a_data_o);
      end else begin
        ea = qa.pop_front();
        chk("a_data", a_data_o, ea.d);
        chk("a_op", a_op_o, ea.op);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_extra: got beat %h, required none", b_data_o);
      end else begin
        eb = qb.pop_front();
        chk("b_data", b_data_o, eb.d);
        chk("b_op", b_op_o, eb.op);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && c_track) begin
      chk("c_busy", c_busy, inflight != 0);
      if (c_stall_prev) begin
        chk("c_stall_valid", c_out_valid, 1'b1);
        chk("c_stall_data", c_data_o, c_hold_d);
        chk("c_stall_op", c_op_o, c_hold_op);
      end
      inflight = inflight + int'(c_in_valid && c_in_ready) - int'(c_out_valid && c_out_ready);
    end
    c_stall_prev = rst_n && c_track && c_out_valid && !c_out_ready;
    c_hold_d     = c_data_o;
    c_hold_op    = c_op_o;
    if (rst_n && c_out_valid && c_out_ready) begin
      if (qc.size() == 0) begin
        checks++; errors++;
        $display("FAIL c_extra: got beat %h, required none", c_data_o);
      end else begin
        ec = qc.pop_front();
        chk("c_data", c_data_o, ec.d);
        chk("c_op", c_op_o, ec.op);
      end
    end
  end

  always @(posedge clk) begin
    #1 c_rnd_ready = 1'($urandom_range(0, 1));
  end

  a_c_in_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (c_in_valid && !c_in_ready && !c_clear) |=> (c_in_valid && $stable(c_data_i) && $stable(c_op_i)))
    else begin
      errors++;
      $display("FAIL c_in_stable: input changed while stalled, required stable");
    end

  initial begin
    logic [255:0] d;
    logic op;
    rst_n = 1'b0;
    {a_clear, a_in_valid, a_op_i, a_data_i} = '0;
    {b_clear, b_in_valid, b_op_i, b_data_i} = '0;
    {c_clear, c_in_valid, c_op_i, c_data_i} = '0;
    a_out_ready = 1'b1; b_out_ready = 1'b1;
    c_rand = 1'b0; c_ready_val = 1'b1; c_track = 1'b0;
    #12;
    chk("a_rst_valid", a_out_valid, 1'b0); chk("a_rst_data", a_data_o, '0);
    chk("a_rst_busy", a_busy, 1'b0);       chk("a_rst_ready", a_in_ready, 1'b1);
    chk("b_rst_valid", b_out_valid, 1'b0); chk("b_rst_data", b_data_o, '0);
    chk("b_rst_op", b_op_o, 1'b0);         chk("b_rst_ready", b_in_ready, 1'b1);
    chk("c_rst_valid", c_out_valid, 1'b0); chk("c_rst_busy", c_busy, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    send(0, A_IN, 1'b0, A_FWD, 1'b1);
    lat_check(0, 1);
    send(0, A_IN, 1'b1, A_INV, 1'b1);
    send(0, A_FWD, 1'b1, A_IN, 1'b1);
    send(1, B_IN, 1'b0, B_FWD, 1'b1);
    lat_check(1, 2);
    send(1, B_IN, 1'b1, B_INV, 1'b1);
    send(1, B_FWD, 1'b1, B_IN, 1'b1);

    c_track = 1'b1; c_rand = 1'b1;
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      d = '0;
      d[191:0] = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      op = 1'($urandom_range(0, 1));
      send(2, d, op, model(d, 6, op), 1'b1);
    end
    c_rand = 1'b0; c_ready_val = 1'b1;
    drain();
    @(posedge clk); #1;
    c_track = 1'b0;

    c_ready_val = 1'b0;
    for (int i = 0; i < 3; i++) send(2, {8{32'hA5A50000 + i}}, 1'b1, '0, 1'b0);
    @(negedge clk);
    chk("c_full_ready", c_in_ready, 1'b0);
    chk("c_full_valid", c_out_valid, 1'b1);
    chk("c_full_busy", c_busy, 1'b1);
    @(posedge clk); #1 c_clear = 1'b1;
    @(posedge clk); #1 c_clear = 1'b0;
    @(negedge clk);
    chk("c_clr_valid", c_out_valid, 1'b0); chk("c_clr_busy", c_busy, 1'b0);
    chk("c_clr_data", c_data_o, '0);       chk("c_clr_ready", c_in_ready, 1'b1);
    chk("c_clr_op", c_op_o, 1'b0);

    @(posedge clk); #1;
    c_ready_val = 1'b1; c_clear = 1'b1; c_in_valid = 1'b1; c_data_i = C_IN;
    @(negedge clk) chk("c_clr_hs_ready", c_in_ready, 1'b1);
    @(posedge clk); #1 c_clear = 1'b0; c_in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk) chk("c_discard_valid", c_out_valid, 1'b0);
    end

    @(posedge clk); #1;
    send(2, {6{32'h5A5A5A5A}}, 1'b0, '0, 1'b0);
    chk("c_pre_rst_busy", c_busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("c_arst_busy", c_busy, 1'b0);      chk("c_arst_valid", c_out_valid, 1'b0);
    chk("c_arst_data", c_data_o, '0);      chk("c_arst_ready", c_in_ready, 1'b1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    send(2, {64'h0, C_IN}, 1'b0, {64'h0, C_FWD}, 1'b1);
    lat_check(2, 3);

    drain();
    repeat (2) @(negedge clk);
    chk("qa_left", qa.size(), 0);
    chk("qb_left", qb.size(), 0);
    chk("qc_left", qc.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
